// File: rtl/instr_controller.sv
// Sequencing control unit for the 16-bit processor: fetch, decode and execute
// one instruction at a time, driving PC, IR, data memory, register file and ALU.
module instr_controller (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [15:0] IR,
    input  logic [6:0]  PC_Addr,
    output logic        PC_Clr,
    output logic        PC_Up,
    output logic        IR_Ld,
    output logic [7:0]  D_Addr,
    output logic        D_Wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_Addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_Addr,
    output logic [3:0]  RF_Rb_Addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_NOOP   = 4'd9
    } state_t;

    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  w_opcode;
    logic        w_pc_at_end;

    assign w_opcode    = IR[15:12];
    assign w_pc_at_end = (PC_Addr == 7'd127);
    assign State       = r_state;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_STORE: w_next = S_STORE;
                    OP_LOAD:  w_next = S_LOAD_A;
                    OP_ADD:   w_next = S_ADD;
                    OP_SUB:   w_next = S_SUB;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_NOOP:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        PC_Clr     = 1'b1;
        PC_Up      = 1'b0;
        IR_Ld      = 1'b0;
        D_Addr     = 8'd0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        ALU_s0     = ALU_PASS;
        case (r_state)
            S_INIT: begin
                PC_Clr = 1'b0;
            end
            S_FETCH: begin
                IR_Ld = 1'b1;
                // PC saturates at the last word; that word is re-fetched until it halts
                PC_Up = ~w_pc_at_end;
            end
            S_LOAD_A: begin
                D_Addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = IR[3:0];
            end
            S_LOAD_B: begin
                // Data memory read is registered, so the write lands one state later
                D_Addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = IR[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = IR[7:0];
                RF_Ra_Addr = IR[11:8];
                D_Wr       = 1'b1;
            end
            S_ADD: begin
                RF_Ra_Addr = IR[11:8];
                RF_Rb_Addr = IR[7:4];
                RF_W_Addr  = IR[3:0];
                ALU_s0     = ALU_ADD;
                RF_W_en    = 1'b1;
            end
            S_SUB: begin
                RF_Ra_Addr = IR[11:8];
                RF_Rb_Addr = IR[7:4];
                RF_W_Addr  = IR[3:0];
                ALU_s0     = ALU_SUB;
                RF_W_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
